// File: rtl/serial_transmitter.sv
// rtl/serial_transmitter.sv - 7-bit odd-parity frame serializer (start, d[0..6], parity, stop) with valid/ready input buffer
// Optional macro SERIAL_TX_FIFO_EN replaces the single holding register with a FIFO_DEPTH-entry FIFO.
module serial_transmitter #(
   parameter int IDLE_GAP   = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [6:0] in_data,
   output logic       serial_out,
   output logic       busy,
   output logic       frame_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

   localparam int         GAP_LAST_I = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
   localparam logic [3:0] GAP_LAST   = GAP_LAST_I[3:0];

   logic       push;
   logic       pop;
   logic       buf_empty;
   logic [6:0] buf_data;

   state_t     state, state_n;
   logic [6:0] shift, shift_n;
   logic       parity, parity_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [3:0] gap_cnt, gap_cnt_n;
   logic       line_n;
   logic       frame_end;

   assign push = in_valid && in_ready;

`ifdef SERIAL_TX_FIFO_EN
   localparam int             PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH = FIFO_DEPTH[PTR_W:0];

   logic [6:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;

   assign in_ready  = (count < DEPTH);
   assign buf_empty = (count == '0);
   assign buf_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // Power-of-2 depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
`else
   logic       hold_valid;
   logic [6:0] hold_data;

   assign in_ready  = !hold_valid;
   assign buf_empty = !hold_valid;
   assign buf_data  = hold_data;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (push) begin
         hold_valid <= 1'b1;
         hold_data  <= in_data;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   // serial_out is registered, so each branch sets the line level for the state being entered.
   always_comb begin
      state_n   = state;
      shift_n   = shift;
      parity_n  = parity;
      bit_cnt_n = bit_cnt;
      gap_cnt_n = gap_cnt;
      line_n    = 1'b1;
      pop       = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (!buf_empty) begin
               state_n = START;
               pop     = 1'b1;
               line_n  = 1'b0;
            end
         end
         START: begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
            line_n    = shift[0];
         end
         DATA: begin
            if (bit_cnt == 3'd6) begin
               state_n = PARITY;
               line_n  = parity;
            end else begin
               bit_cnt_n = bit_cnt + 3'd1;
               shift_n   = shift >> 1;
               line_n    = shift[1];
            end
         end
         PARITY: state_n = STOP;
         STOP: begin
            if (IDLE_GAP > 0) begin
               state_n   = GAP;
               gap_cnt_n = 4'd0;
            end else begin
               frame_end = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) frame_end = 1'b1;
            else                     gap_cnt_n = gap_cnt + 4'd1;
         end
         default: state_n = IDLE;
      endcase
      if (frame_end) begin
         if (!buf_empty) begin
            state_n = START;
            pop     = 1'b1;
            line_n  = 1'b0;
         end else begin
            state_n = IDLE;
         end
      end
      if (pop) begin
         shift_n  = buf_data;
         parity_n = ~^buf_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         shift      <= '0;
         parity     <= 1'b0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         serial_out <= 1'b1;
      end else begin
         state      <= state_n;
         shift      <= shift_n;
         parity     <= parity_n;
         bit_cnt    <= bit_cnt_n;
         gap_cnt    <= gap_cnt_n;
         serial_out <= line_n;
      end
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == STOP);

endmodule

// File: tb/tb_serial_transmitter.sv
// tb/tb_serial_transmitter.sv - serial_transmitter checked against a frame-position model (IDLE_GAP 0 and 3 instances)
`timescale 1ns/1ps
module tb_serial_transmitter;
   localparam int FIFO_DEPTH = 4;
`ifdef SERIAL_TX_FIFO_EN
   localparam int CAP = FIFO_DEPTH;
`else
   localparam int CAP = 1;
`endif

   logic       clk  = 1'b0;
   logic       rstn = 1'b1;
   logic [1:0] vld  = '0;
   logic [1:0] rdy, so, bsy, fd;
   logic [6:0] dat [2];

   always #5 clk = ~clk;

   serial_transmitter #(.IDLE_GAP(0), .FIFO_DEPTH(FIFO_DEPTH)) dut0 (
      .clk(clk), .rstn(rstn), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
      .serial_out(so[0]), .busy(bsy[0]), .frame_done(fd[0]));

   serial_transmitter #(.IDLE_GAP(3), .FIFO_DEPTH(FIFO_DEPTH)) dut1 (
      .clk(clk), .rstn(rstn), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
      .serial_out(so[1]), .busy(bsy[1]), .frame_done(fd[1]));

   int checks = 0;
   int errors = 0;

   // Reference: queue of accepted words plus the position (0..9+gap) inside the current frame.
   logic [6:0] mq [2][8];
   int         mhead [2];
   int         mcnt  [2];
   logic [6:0] mw    [2];
   int         mpos  [2];
   bit         mact  [2];

   // Upstream word sources, one per instance.
   logic [6:0] src [2][64];
   int         shead [2];
   int         stail [2];

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_line(input int i);
      int p;
      p = mpos[i];
      if (!mact[i])   return 1'b1;
      if (p == 0)     return 1'b0;
      if (p <= 7)     return mw[i][p-1];
      if (p == 8)     return ~^mw[i];
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mhead[i] = 0; mcnt[i] = 0; mact[i] = 0; mpos[i] = 0; mw[i] = '0;
         shead[i] = stail[i];
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit acc;
         acc = vld[i] && (mcnt[i] < CAP);
         if (mact[i] && mpos[i] < 9 + gap_of(i)) begin
            mpos[i]++;
         end else if (mcnt[i] > 0) begin
            mw[i]    = mq[i][mhead[i]];
            mhead[i] = (mhead[i] + 1) % 8;
            mcnt[i]--;
            mact[i]  = 1;
            mpos[i]  = 0;
         end else begin
            mact[i] = 0;
         end
         if (acc) begin
            mq[i][(mhead[i] + mcnt[i]) % 8] = dat[i];
            mcnt[i]++;
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         vld[i] = rstn && (shead[i] != stail[i]);
         dat[i] = (shead[i] != stail[i]) ? src[i][shead[i] % 64] : 7'h00;
      end
   endtask

   task automatic add_both(input logic [6:0] w);
      for (int i = 0; i < 2; i++) begin
         src[i][stail[i] % 64] = w;
         stail[i]++;
      end
   endtask

   task automatic compare();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("dut%0d serial_out", i), so[i], exp_line(i));
         check($sformatf("dut%0d busy", i), bsy[i], mact[i]);
         check($sformatf("dut%0d frame_done", i), fd[i], mact[i] && mpos[i] == 9);
         check($sformatf("dut%0d in_ready", i), rdy[i], mcnt[i] < CAP);
      end
   endtask

   // One clock: model the edge, retire accepted source words, compare on the falling edge.
   task automatic cycle();
      bit dacc [2];
      for (int i = 0; i < 2; i++) dacc[i] = vld[i] && rdy[i];
      @(posedge clk);
      if (!rstn) model_reset();
      else       model_edge();
      for (int i = 0; i < 2; i++) if (dacc[i]) shead[i]++;
      @(negedge clk);
      compare();
      drive();
   endtask

   initial begin
      logic [10:0] e55;
      int          nacc;
      int          gapc [2];
      bit          seen [2];
      bit          done [2];
      bit          hit;

      for (int i = 0; i < 2; i++) begin
         shead[i] = 0; stail[i] = 0; dat[i] = '0;
      end
      model_reset();
      #2 rstn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("reset serial_out", so[i], 1'b1);
         check("reset in_ready", rdy[i], 1'b1);
         check("reset busy", bsy[i], 1'b0);
         check("reset frame_done", fd[i], 1'b0);
      end
      repeat (20) cycle();
      rstn = 1'b1;
      drive();
      repeat (3) cycle();

      // Single word 7'h55: line is 0,1,0,1,0,1,0,1,1,1 then idle high.
      e55 = 11'b11110101010;
      add_both(7'h55);
      drive();
      cycle();
      for (int k = 0; k <= 10; k++) begin
         cycle();
         check($sformatf("frame55 bit%0d", k), so[0], e55[k]);
         check($sformatf("frame55 done%0d", k), fd[0], k == 9);
      end
      repeat (5) cycle();

      // Parity corners: bit position 8 after the start bit.
      add_both(7'h00);
      drive();
      repeat (10) cycle();
      check("parity 00 dut0", so[0], 1'b1);
      check("parity 00 dut1", so[1], 1'b1);
      repeat (8) cycle();
      add_both(7'h7F);
      drive();
      repeat (10) cycle();
      check("parity 7f dut0", so[0], 1'b0);
      check("parity 7f dut1", so[1], 1'b0);
      repeat (8) cycle();

      // Back-to-back: high cycles between stop bit and next start bit equal IDLE_GAP.
      add_both(7'h12);
      add_both(7'h34);
      drive();
      for (int i = 0; i < 2; i++) begin
         gapc[i] = 0; seen[i] = 0; done[i] = 0;
      end
      for (int n = 0; n < 60 && !(done[0] && done[1]); n++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            if (fd[i]) seen[i] = 1;
            else if (seen[i] && !done[i]) begin
               if (so[i]) gapc[i]++;
               else       done[i] = 1;
            end
         end
      end
      check("b2b second start dut0", done[0], 1'b1);
      check("b2b second start dut1", done[1], 1'b1);
      check("b2b gap dut0", gapc[0], 0);
      check("b2b gap dut1", gapc[1], 3);
      repeat (30) cycle();

      // Burst of six words with in_valid held high.
      for (int w = 1; w <= 6; w++) add_both(7'(w));
      drive();
      nacc = 0;
      for (int e = 0; e <= 4; e++) begin
         if (vld[0] && rdy[0]) nacc++;
         cycle();
      end
      check("burst accepts by E4", nacc, (CAP > 1) ? 5 : 2);
      repeat (100) cycle();

      // Reset during d[3] with words still queued upstream/buffered.
      add_both(7'h2A);
      add_both(7'h15);
      add_both(7'h33);
      drive();
      hit = 0;
      for (int n = 0; n < 40 && !hit; n++) begin
         cycle();
         hit = mact[0] && mpos[0] == 4;
      end
      check("reach d3", hit, 1'b1);
      rstn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("midreset serial_out", so[i], 1'b1);
         check("midreset busy", bsy[i], 1'b0);
         check("midreset in_ready", rdy[i], 1'b1);
      end
      model_reset();
      drive();
      repeat (2) cycle();
      rstn = 1'b1;
      drive();
      repeat (15) cycle();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 5) == 0 && (stail[0] - shead[0]) < 4)
            add_both(7'($urandom_range(0, 127)));
         drive();
         cycle();
      end
      repeat (120) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Parallel-to-serial transmitter that drives the `serial_in` line of the team's 7-bit odd-parity serial receiver. It accepts 7-bit words over a valid/ready handshake and buffers them. Each word goes out as one 10-bit frame, one bit per clk: start bit, data bits LSB first, parity bit, stop bit. The line idles high between frames.

## Interface
- `IDLE_GAP`, default 0: extra idle-high cycles inserted after each stop bit. Legal range 0..15.
- `FIFO_DEPTH`, default 4: input buffer depth. Used only when `SERIAL_TX_FIFO_EN` is defined. Must be a power of 2, ≥2.
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  transmitter can accept a word this cycle
- `in_data`  in  7  word to transmit
- `serial_out`  out  1  registered serial line, idle high
- `busy`  out  1  frame or gap in progress
- `frame_done`  out  1  one-cycle pulse during the stop-bit cycle

## Operation
- A word is accepted at a clk edge where `in_valid && in_ready` is true.
- While `in_ready` is low, `in_valid` is ignored. Upstream holds `in_data` stable until the word is accepted.
- Buffer behaviour without the macro:
  - The buffer is a single holding register.
  - `in_ready` = holding register empty.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE → START when the buffer is non-empty. On that edge the word is popped into the shift register and `serial_out` <= 0.
- START → DATA, where `serial_out` = d[0].
- DATA runs 7 cycles, emitting d[0]..d[6]. A 3-bit counter selects the bit; shift right LSB first.
- PARITY: `serial_out` = ~^d[6:0]. The total count of ones across data and parity is odd.
- STOP: `serial_out` = 1 and `frame_done` = 1.
- Leaving STOP:
  - If `IDLE_GAP`=0: go to START if the buffer is non-empty (pop on the same edge), else to IDLE.
  - If `IDLE_GAP`>0: go to GAP for `IDLE_GAP` cycles with `serial_out` = 1, then apply the same rule.
- `busy` = 1 in START, DATA, PARITY, STOP and GAP; 0 in IDLE.
- A push and a pop on the same edge are both performed.
- `in_ready` never depends on a same-cycle pop: when the buffer is full, `in_ready` = 0 even on a pop edge.
- Reset, including mid-frame, aborts the frame:
  - `serial_out` goes to 1 immediately (asynchronous).
  - The buffer is emptied and the FSM returns to IDLE.
  - No partial frame resumes.
- Reset values: `serial_out`=1, `in_ready`=1, `busy`=0, `frame_done`=0.

## Timing
- Accept edge E0. The buffer becomes non-empty after E0, so START is entered at E1.
- `serial_out` by cycle:
  - E1–E2: start bit (0).
  - E(2+k)–E(3+k): d[k], for k = 0..6.
  - E9–E10: parity bit.
  - E10–E11: stop bit (1), with `frame_done`=1.
- Frame length is 10 cycles. Latency from accept edge to the first start-bit cycle is 1 cycle.
- Back-to-back frames with `IDLE_GAP`=0: the next start bit begins at E11, immediately after the stop bit. The receiver's falling-edge detection requires exactly this stop(1)→start(0) sequence, with no gap needed.
- Frame period is 10+`IDLE_GAP` cycles.
- Holding-register mode: `in_ready` rises the cycle after the pop edge. A second word accepted during a frame is transmitted with no extra gap.

## Configuration
- `SERIAL_TX_FIFO_EN` defined:
  - The buffer is a `FIFO_DEPTH`-entry circular FIFO with wrapping read/write pointers and an occupancy counter.
  - `in_ready` = (count < `FIFO_DEPTH`).
  - Words are transmitted in strict acceptance order.
- `SERIAL_TX_FIFO_EN` undefined:
  - A single holding register is used and `FIFO_DEPTH` is ignored.
  - All other behaviour and timing is identical.

## Test plan
- Reset: assert `rstn`=0 → `serial_out`=1, `in_ready`=1, `busy`=0, `frame_done`=0. Hold reset 20 cycles → line stays 1.
- Single word 7'h55 → `serial_out` over E1..E11 = 0,1,0,1,0,1,0,1,1,1, then 1 while idle. `frame_done` is high only in E10–E11. A paired receiver reports `data_out`=7'h55, `parity_ok_n`=0.
- Parity corners:
  - 7'h00 → parity bit 1.
  - 7'h7F → parity bit 0.
  - Receiver reports `parity_ok_n`=0 for both.
- Back-to-back with `IDLE_GAP`=0: push 7'h12 then 7'h34 on consecutive edges → stop of frame 1 at E10–E11, start of frame 2 at E11. The receiver asserts `ready` twice with 7'h12 then 7'h34. With `IDLE_GAP`=3 → exactly 3 extra high cycles between the frames.
- `SERIAL_TX_FIFO_EN`, `FIFO_DEPTH`=4: hold `in_valid`=1 with words 1..6 →
  - 5 words accepted by E4: 1 popped at E1, 4 buffered.
  - `in_ready`=0 until the next pop.
  - All 6 words are transmitted in order.
  - Pointer wrap is exercised.
- Reset mid-frame, during d[3], with 2 words buffered → `serial_out`=1 immediately, `busy`=0, buffer empty. After release, no frame starts until a new push.
